audio_level_accumulator: RTL

//  Upstream feeder for the PicoBlaze display/control block. Consumes signed audio

---
 rtl/audio_level_accumulator_if.sv | 23 ++
 rtl/audio_level_accumulator.sv | 99 +++++++++
 2 files changed

// File: rtl/audio_level_accumulator_if.sv
// Sample-in / level-out bundle between the audio front end and the level accumulator.
// The master side feeds samples and enable; the slave side publishes the block statistics.
interface audio_level_accumulator_if #(
  parameter int SAMPLE_W = 8
) ();
  logic                enable;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic [SAMPLE_W-1:0] level_avg;
  logic [SAMPLE_W-1:0] level_peak;
  logic                level_strobe;
  logic [7:0]          block_count;

  modport master (
    output enable, sample_valid, sample_data,
    input  level_avg, level_peak, level_strobe, block_count
  );

  modport slave (
    input  enable, sample_valid, sample_data,
    output level_avg, level_peak, level_strobe, block_count
  );
endinterface

// File: rtl/audio_level_accumulator.sv
// Accumulates |sample| over blocks of 2**LOG2_N samples and publishes mean and peak
// magnitude with a one-cycle strobe at the end of every complete block.
//
// state | meaning
// IDLE  | disabled; accumulators held at zero, samples ignored
// ACCUM | accumulating magnitudes; block closes on the last valid sample
module audio_level_accumulator #(
  parameter int SAMPLE_W = 8,
  parameter int LOG2_N   = 8
) (
  input logic                  clk,
  input logic                  reset,
  audio_level_accumulator_if.slave bus
);
  localparam int MAG_W = SAMPLE_W + 1;
  localparam int ACC_W = MAG_W + LOG2_N;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [LOG2_N-1:0]   cnt;
  logic [MAG_W-1:0]    peak_run;
  logic [SAMPLE_W-1:0] level_avg_q;
  logic [SAMPLE_W-1:0] level_peak_q;
  logic                level_strobe_q;
  logic [7:0]          block_count_q;

  logic [MAG_W-1:0]    sample_ext;
  logic [MAG_W-1:0]    mag;
  logic [ACC_W-1:0]    acc_next;
  logic [MAG_W-1:0]    peak_next;
  logic [ACC_W-1:0]    avg_full;
  logic [SAMPLE_W-1:0] avg_sat;
  logic [SAMPLE_W-1:0] peak_sat;
  logic                last_sample;

  // One extra bit so the most-negative sample negates to a positive magnitude.
  assign sample_ext  = {bus.sample_data[SAMPLE_W-1], bus.sample_data};
  assign mag         = sample_ext[MAG_W-1] ? (~sample_ext + 1'b1) : sample_ext;
  assign acc_next    = acc + ACC_W'(mag);
  assign peak_next   = (mag > peak_run) ? mag : peak_run;
  assign avg_full    = acc_next >> LOG2_N;
  assign avg_sat     = (|avg_full[ACC_W-1:SAMPLE_W]) ? '1 : avg_full[SAMPLE_W-1:0];
  assign peak_sat    = peak_next[SAMPLE_W] ? '1 : peak_next[SAMPLE_W-1:0];
  assign last_sample = (cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      peak_run       <= '0;
      level_avg_q    <= '0;
      level_peak_q   <= '0;
      level_strobe_q <= 1'b0;
      block_count_q  <= '0;
    end else begin
      level_strobe_q <= 1'b0;
      case (state)
        IDLE: begin
          acc      <= '0;
          cnt      <= '0;
          peak_run <= '0;
          if (bus.enable) state <= ACCUM;
        end
        ACCUM: begin
          // Enable wins over a coincident sample: the partial block is dropped.
          if (!bus.enable) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            peak_run <= '0;
          end else if (bus.sample_valid) begin
            if (last_sample) begin
              level_avg_q    <= avg_sat;
              level_peak_q   <= peak_sat;
              level_strobe_q <= 1'b1;
              block_count_q  <= block_count_q + 8'd1;
              acc            <= '0;
              cnt            <= '0;
              peak_run       <= '0;
            end else begin
              acc      <= acc_next;
              cnt      <= cnt + 1'b1;
              peak_run <= peak_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.level_avg    = level_avg_q;
  assign bus.level_peak   = level_peak_q;
  assign bus.level_strobe = level_strobe_q;
  assign bus.block_count  = block_count_q;
endmodule
